// File: rtl/spi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spi_bus_arbiter
//
// Shares one physical SPI bus among PORTS independent SPI masters using a
// registered request/grant handshake. Ownership only changes between
// transactions. A programmable guard interval, during which the bus is held
// idle, is inserted before every new grant.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   enable       gate for new grants (an existing owner is never revoked)
//   req          per-port bus request, held for the whole ownership
//   grant        one-hot ownership, registered
//   busy         high while a grant is pending (guard) or held
//   owner        index of the current or pending owner
//   mosi/sck/ss_L  shared bus outputs
//   miso         shared bus input
//   mosi_ports/sck_ports/ss_L_ports  per-port master outputs
//   miso_ports   per-port MISO; only the owner sees the bus MISO
//
// States:
//   S_IDLE  | bus idle, arbitrating when enabled
//   S_GUARD | winner chosen, bus held idle for GUARD_CYCLES+1 edges
//   S_OWNED | bus routed to owner until request drops with ss_L high
// -----------------------------------------------------------------------------
module spi_bus_arbiter #(
    parameter int PORTS        = 3,
    parameter bit RR_MODE      = 1'b1,
    parameter int GUARD_CYCLES = 2,
    parameter bit SCK_IDLE     = 1'b0,
    localparam int OW          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [PORTS-1:0] req,
    output logic [PORTS-1:0] grant,
    output logic             busy,
    output logic [OW-1:0]    owner,
    output logic             mosi,
    input  logic             miso,
    output logic             sck,
    output logic             ss_L,
    input  logic [PORTS-1:0] mosi_ports,
    output logic [PORTS-1:0] miso_ports,
    input  logic [PORTS-1:0] sck_ports,
    input  logic [PORTS-1:0] ss_L_ports
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_OWNED = 2'd2
    } state_t;

    localparam logic [7:0] GUARD_INIT = 8'(GUARD_CYCLES);

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    last_q,  last_d;
    logic [7:0]       cnt_q,   cnt_d;
    logic [PORTS-1:0] grant_q, grant_d;

    logic [PORTS-1:0] owner_oh;
    logic             req_own;
    logic             ss_own;
    logic             mosi_own;
    logic             sck_own;
    logic [OW-1:0]    winner;
    logic             found;
    int               idx;
    logic             owned;

    // Per-port fields of the registered owner, selected by comparison loops
    // so that non-power-of-two PORTS never produce an out-of-range index.
    always_comb begin
        owner_oh = '0;
        req_own  = 1'b0;
        ss_own   = 1'b1;
        mosi_own = 1'b0;
        sck_own  = SCK_IDLE;
        for (int i = 0; i < PORTS; i++) begin
            if (owner_q == OW'(i)) begin
                owner_oh[i] = 1'b1;
                req_own     = req[i];
                ss_own      = ss_L_ports[i];
                mosi_own    = mosi_ports[i];
                sck_own     = sck_ports[i];
            end
        end
    end

    // Winner selection. Round-robin searches last+1, last+2, ... with wrap;
    // fixed priority lets the highest set index overwrite lower ones.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (RR_MODE) begin
            for (int k = 1; k <= PORTS; k++) begin
                idx = (int'(last_q) + k) % PORTS;
                for (int j = 0; j < PORTS; j++) begin
                    if (!found && (j == idx) && req[j]) begin
                        winner = OW'(j);
                        found  = 1'b1;
                    end
                end
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (req[i]) begin
                    winner = OW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= OW'(PORTS - 1);
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (enable && (|req)) begin
                    owner_d = winner;
                    cnt_d   = GUARD_INIT;
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                // An abandoned request cancels the pending grant without
                // advancing the round-robin pointer.
                if (!req_own) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd0) begin
                    grant_d = owner_oh;
                    state_d = S_OWNED;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_OWNED: begin
                // Release only with chip-select deasserted, so a dropped
                // request never truncates a transaction in flight.
                if (!req_own && ss_own) begin
                    grant_d = '0;
                    last_d  = owner_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign owned = (state_q == S_OWNED);

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);
    assign owner = owner_q;
    assign mosi  = owned ? mosi_own : 1'b0;
    assign sck   = owned ? sck_own  : SCK_IDLE;
    assign ss_L  = owned ? ss_own   : 1'b1;

    always_comb begin
        miso_ports = '0;
        for (int i = 0; i < PORTS; i++) begin
            miso_ports[i] = owned && owner_oh[i] && miso;
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       miso;
    logic [2:0] mp, sp, ssp;
    logic [2:0] req_a, req_b;
    logic [0:0] req_c;

    logic [2:0] grant_a, miso_a;
    logic [1:0] owner_a;
    logic       busy_a, mosi_a, sck_a, ss_a;

    logic [2:0] grant_b, miso_b;
    logic [1:0] owner_b;
    logic       busy_b, mosi_b, sck_b, ss_b;

    logic [0:0] grant_c, miso_c;
    logic [0:0] owner_c;
    logic       busy_c, mosi_c, sck_c, ss_c;
    logic [0:0] mp_c, sp_c, ssp_c;

    int tests = 0;
    int fails = 0;
    int exp_seq [4] = '{1, 2, 0, 1};

    assign mp_c  = mp[0:0];
    assign sp_c  = sp[0:0];
    assign ssp_c = ssp[0:0];

    always #5 clk = ~clk;

    spi_bus_arbiter #(.PORTS(3), .RR_MODE(1'b1), .GUARD_CYCLES(2), .SCK_IDLE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .req(req_a), .grant(grant_a),
        .busy(busy_a), .owner(owner_a), .mosi(mosi_a), .miso(miso), .sck(sck_a),
        .ss_L(ss_a), .mosi_ports(mp), .miso_ports(miso_a), .sck_ports(sp),
        .ss_L_ports(ssp)
    );

    spi_bus_arbiter #(.PORTS(3), .RR_MODE(1'b0), .GUARD_CYCLES(0), .SCK_IDLE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .req(req_b), .grant(grant_b),
        .busy(busy_b), .owner(owner_b), .mosi(mosi_b), .miso(miso), .sck(sck_b),
        .ss_L(ss_b), .mosi_ports(mp), .miso_ports(miso_b), .sck_ports(sp),
        .ss_L_ports(ssp)
    );

    spi_bus_arbiter #(.PORTS(1), .RR_MODE(1'b1), .GUARD_CYCLES(2), .SCK_IDLE(1'b0)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .req(req_c), .grant(grant_c),
        .busy(busy_c), .owner(owner_c), .mosi(mosi_c), .miso(miso), .sck(sck_c),
        .ss_L(ss_c), .mosi_ports(mp_c), .miso_ports(miso_c), .sck_ports(sp_c),
        .ss_L_ports(ssp_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; miso = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;
        mp = 3'b111; sp = 3'b111; ssp = 3'b000;
        step(3);

        // reset state: bus idle even with ports driving active levels
        chk("rst_grant",  grant_a, 0);
        chk("rst_busy",   busy_a,  0);
        chk("rst_owner",  owner_a, 0);
        chk("rst_mosi",   mosi_a,  0);
        chk("rst_sck",    sck_a,   0);
        chk("rst_ss",     ss_a,    1);
        chk("rst_miso",   miso_a,  0);
        chk("rst_b_ss",   ss_b,    1);
        chk("rst_c_miso", miso_c,  0);

        rst = 1'b0; mp = '0; sp = '0; ssp = 3'b111; miso = 1'b0;
        step(1);

        // fixed priority with zero guard: grant one edge after request sampled
        req_b = 3'b011;
        step(1);
        chk("fp_busy",   busy_b,  1);
        chk("fp_owner",  owner_b, 1);
        chk("fp_g_pend", grant_b, 0);
        step(1);
        chk("fp_grant1", grant_b, 3'b010);
        req_b = 3'b001;
        step(1);
        chk("fp_rel",    grant_b, 0);
        step(1);
        chk("fp_owner0", owner_b, 0);
        chk("fp_g_pend2", grant_b, 0);
        step(1);
        chk("fp_grant0", grant_b, 3'b001);
        req_b = '0;
        step(1);
        chk("fp_rel0",   grant_b, 0);

        // single-port build
        req_c = 1'b1;
        step(1);
        chk("p1_busy",  busy_c,  1);
        step(2);
        chk("p1_pend",  grant_c, 0);
        step(1);
        chk("p1_grant", grant_c, 1);
        ssp = 3'b110;
        #1;
        chk("p1_ss",    ss_c,    0);
        ssp = 3'b111;
        req_c = 1'b0;
        step(1);
        chk("p1_rel",   grant_c, 0);

        // basic grant latency and data path
        req_a = 3'b001;
        step(1);
        chk("t1_busy",  busy_a,  1);
        chk("t1_owner", owner_a, 0);
        chk("t1_g0",    grant_a, 0);
        step(2);
        chk("t1_g_pend", grant_a, 0);
        chk("t1_ss_idle", ss_a,  1);
        step(1);
        chk("t1_grant", grant_a, 3'b001);
        ssp = 3'b110; sp = 3'b010; mp = 3'b001; miso = 1'b1;
        #1;
        chk("t1_ss",    ss_a,    0);
        chk("t1_sck0",  sck_a,   0);
        chk("t1_mosi",  mosi_a,  1);
        chk("t1_miso",  miso_a,  3'b001);
        sp = 3'b011;
        #1;
        chk("t1_sck1",  sck_a,   1);
        miso = 1'b0;
        #1;
        chk("t1_miso0", miso_a,  0);

        // protected release: request dropped while chip-select still low
        req_a = '0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_hold", grant_a, 3'b001);
        end
        ssp = 3'b111;
        step(1);
        chk("t4_rel",   grant_a, 0);
        chk("t4_busy",  busy_a,  0);
        chk("t4_ss",    ss_a,    1);
        chk("t4_sck",   sck_a,   0);
        chk("t4_mosi",  mosi_a,  0);

        // round-robin: last owner was port 0, so order is 1,2,0,1
        sp = 3'b111; mp = '0;
        req_a = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("rr_owner", owner_a, exp_seq[k]);
            chk("rr_gidle", grant_a, 0);
            chk("rr_ssidl", ss_a,    1);
            chk("rr_sckid", sck_a,   0);
            step(3);
            chk("rr_grant", grant_a, 3'b001 << exp_seq[k]);
            chk("rr_sck",   sck_a,   1);
            req_a = 3'b111 & ~(3'b001 << exp_seq[k]);
            step(1);
            chk("rr_rel",   grant_a, 0);
            req_a = (k < 3) ? 3'b111 : 3'b000;
        end

        // enable gate
        enable = 1'b0;
        req_a = 3'b100;
        step(4);
        chk("t5_grant", grant_a, 0);
        chk("t5_busy",  busy_a,  0);
        enable = 1'b1;
        step(1);
        chk("t5_owner", owner_a, 2);
        step(2);
        chk("t5_pend",  grant_a, 0);
        step(1);
        chk("t5_grant1", grant_a, 3'b100);
        enable = 1'b0;
        step(3);
        chk("t5_hold",  grant_a, 3'b100);
        chk("t5_busyh", busy_a,  1);

        // reset in the middle of a transaction
        ssp = 3'b011; sp = 3'b100;
        #1;
        chk("t6_ss_act", ss_a,   0);
        chk("t6_sck_act", sck_a, 1);
        rst = 1'b1;
        step(1);
        chk("t6_grant", grant_a, 0);
        chk("t6_ss",    ss_a,    1);
        chk("t6_sck",   sck_a,   0);
        chk("t6_busy",  busy_a,  0);
        chk("t6_owner", owner_a, 0);
        rst = 1'b0; enable = 1'b1; ssp = 3'b111;
        req_a = 3'b111;
        step(1);
        chk("t6_rr_ptr", owner_a, 0);
        chk("t6_busy1", busy_a,  1);

        // request abandoned during guard cancels the pending grant
        req_a = '0;
        step(1);
        chk("ga_busy",  busy_a,  0);
        step(3);
        chk("ga_grant", grant_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Clocked, request/grant arbiter that shares one physical SPI bus (mosi/miso/sck/ss_L) among PORTS independent SPI masters.
- Successor to the kernel-driven combinational SPI crossbar; ownership is now negotiated in hardware.
- Bus ownership changes only between transactions, separated by a programmable guard interval during which the bus is driven idle.
- Supports any PORTS ≥ 1, fixed-priority or round-robin arbitration, and a kernel enable gate.

Parameters:
PORTS, 3, number of master ports (≥1)
RR_MODE, 1, 0 = fixed priority (highest index wins); 1 = round-robin
GUARD_CYCLES, 2, idle clk cycles inserted before each new grant (0..255)
SCK_IDLE, 0, level driven on sck while no port owns the bus

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  kernel gate; low blocks new grants, does not revoke the current owner
req  input  PORTS  per-port bus request, level-held for entire ownership
grant  output  PORTS  one-hot ownership, registered
busy  output  1  high in GUARD or OWNED
owner  output  OW  index of current or pending owner, OW = max(1,clog2(PORTS))
mosi  output  1  bus MOSI
miso  input  1  bus MISO
sck  output  1  bus SCK
ss_L  output  1  bus chip-select, active-low
mosi_ports  input  PORTS  per-port MOSI
miso_ports  output  PORTS  per-port MISO
sck_ports  input  PORTS  per-port SCK
ss_L_ports  input  PORTS  per-port chip-select

Behaviour:
Reset values:
- grant=0, busy=0, owner=0, mosi=0, sck=SCK_IDLE, ss_L=1, miso_ports=0.
- Round-robin pointer last=PORTS-1, state=IDLE.
- Reset applied mid-transaction: ss_L high and grant=0 from the edge that samples rst.

State machine (registered):
- IDLE
  - Bus idle.
  - If enable && |req: choose winner w, owner←w, cnt←GUARD_CYCLES, go to GUARD.
- GUARD
  - Bus idle.
  - If !req[owner]: return to IDLE; last pointer unchanged.
  - Else if cnt==0: grant←one-hot(owner), go to OWNED.
  - Else cnt←cnt-1.
- OWNED
  - Bus routed to owner.
  - When !req[owner] && ss_L_ports[owner]==1 (both sampled the same edge): grant←0, last←owner, go to IDLE.
  - Request dropped while ss_L_ports[owner]==0: ownership held until ss_L rises; no transaction is ever truncated.
  - enable going low has no effect in OWNED.

Arbitration:
- Fixed priority: highest set index of req wins.
- Round-robin: first set bit searching last+1, last+2, … with wrap modulo PORTS.
- PORTS=1: always port 0.

Latency:
- req sampled high in IDLE at edge t → grant high after edge t+GUARD_CYCLES+1.
- Release sampled at edge r → grant low after r.
- Earliest next grant is after r+GUARD_CYCLES+2, so the bus is idle for ≥ GUARD_CYCLES+1 cycles between owners.
- A new request arriving on the release edge is arbitrated in IDLE on the following edge.

Data path (combinational from registered state/owner, no added SCK latency):
- OWNED: mosi=mosi_ports[owner], sck=sck_ports[owner], ss_L=ss_L_ports[owner], miso_ports has only bit owner = miso.
- Otherwise: mosi=0, sck=SCK_IDLE, ss_L=1, miso_ports=0.
- Non-owners never see miso.

Invariants:
- grant at most one-hot.
- grant≠0 only in OWNED.
- ss_L=1 whenever grant==0.

Test Plan:
1. PORTS=3, RR_MODE=1, GUARD_CYCLES=2; req=3'b001 at edge 10 → grant=001 after edge 13; sck/mosi/ss_L follow port 0; miso_ports[0]=miso, bits 2:1 =0.
2. Round-robin fairness: req=3'b111 held; each owner drops req for 1 cycle after one transaction → grant order 001,010,100,001 with ≥3 idle cycles (ss_L=1, sck=SCK_IDLE) between grants.
3. RR_MODE=0, req=3'b011 → grant=010; after release with req[0] still high → grant=001.
4. Protected release: owner drops req while ss_L_ports[owner]=0 for 5 more cycles → grant held those 5 cycles, drops on the edge sampling ss_L_ports=1.
5. enable=0 with req=3'b100 → grant stays 0, busy=0; enable rises → grant=100 GUARD_CYCLES+2 edges later. Drop enable while OWNED → grant unaffected.
6. Assert rst mid-transaction in OWNED → next edge grant=0, ss_L=1, sck=SCK_IDLE, busy=0. GUARD_CYCLES=0 corner: req sampled edge t → grant after t+1. PORTS=1 build elaborates and grants port 0.
